// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: next-PC select codes,
// the "operand unused" Tuse marker, FSM state encoding and the per-source
// Tuse/Tnew hazard test used by pipe_ctrl.
package pipe_pkg;

    localparam logic [1:0] PC_SEL_SEQ     = 2'd0;
    localparam logic [1:0] PC_SEL_HANDLER = 2'd1;
    localparam logic [1:0] PC_SEL_EPC     = 2'd2;

    // A Tuse of 3 can never be exceeded by a 2-bit Tnew, so unused operands
    // fall out of the hazard test without a special case.
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // True when the D-stage source 'rs' is produced by an older instruction
    // in E or M whose result will not be forwardable by the time D needs it.
    function automatic logic src_hazard(
        input logic [4:0] rs,
        input logic [1:0] tuse,
        input logic       e_wreg,
        input logic [4:0] e_waddr,
        input logic [1:0] e_tnew,
        input logic       m_wreg,
        input logic [4:0] m_waddr,
        input logic [1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = e_wreg & (e_waddr == rs) & (e_tnew > tuse);
        m_hit = m_wreg & (m_waddr == rs) & (m_tnew > tuse);
        return (rs != 5'd0) & (e_hit | m_hit);
    endfunction

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// md_timer: down-counter modelling the busy window of the multi-cycle
// mult/div unit. Loads the unit latency on an accepted issue, counts down to
// zero, and can be cleared when an exception squashes the operation.
module md_timer #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             clear_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, then a load into an idle unit, else count down.
    // An issue while already busy is ignored.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i && (cnt_q == '0)) begin
            cnt_d = is_div_i ? DIV_CNT : MUL_CNT;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register; reset leaves the unit idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the F/D, D/E, E/M and M/W pipeline
// registers. Produces enables/clears and the next-PC select from the
// Tuse/Tnew data-hazard test, the mult/div busy timer and a two-state
// RUN/FLUSH machine that squashes the pipe on exceptions and eret.
// Optional macro PIPE_CTRL_PERF_EN adds stall_cycles / flush_count outputs.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic [4:0]       e_waddr,
    input  logic [4:0]       m_waddr,
    input  logic             e_wreg,
    input  logic             m_wreg,
    input  logic [1:0]       e_tnew,
    input  logic [1:0]       m_tnew,
    input  logic             d_is_md,
    input  logic             md_start,
    input  logic             md_is_div,
    input  logic             exc_req,
    input  logic             eret_req,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             clr_fd,
    output logic             clr_de,
    output logic             clr_em,
    output logic [1:0]       pc_sel,
    output logic             md_busy,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count,
`endif
    output logic             dbg_state,
    output logic [CNT_W-1:0] dbg_md_cnt
);

    state_e state_q;
    state_e state_d;

    logic run;
    logic stall_rs;
    logic stall_rt;
    logic md_stall;
    logic stall;
    logic md_clear;
    logic md_load;

    assign run = (state_q == ST_RUN);

    // Data hazards: D reads a register an older instruction has not yet
    // produced in forwardable form. Register 0 is excluded inside src_hazard.
    assign stall_rs = src_hazard(d_rs, d_tuse_rs, e_wreg, e_waddr, e_tnew,
                                 m_wreg, m_waddr, m_tnew);
    assign stall_rt = src_hazard(d_rt, d_tuse_rt, e_wreg, e_waddr, e_tnew,
                                 m_wreg, m_waddr, m_tnew);

    // A HI/LO consumer in D waits while the unit is busy or being issued.
    assign md_stall = d_is_md & (md_busy | md_start);
    assign stall    = stall_rs | stall_rt | md_stall;

    // Only a committed exception kills an in-flight mult/div; eret does not.
    assign md_clear = run & exc_req;
    assign md_load  = run & md_start;

    md_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (md_load),
        .is_div_i (md_is_div),
        .clear_i  (md_clear),
        .busy_o   (md_busy),
        .cnt_o    (dbg_md_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline controls. Priority in RUN:
    // exception > eret > hazard stall > normal flow. FLUSH is a single
    // recovery cycle in which requests and hazards are not looked at.
    always_comb begin
        state_d = state_q;
        en_pc   = 1'b1;
        en_fd   = 1'b1;
        en_de   = 1'b1;
        en_em   = 1'b1;
        en_mw   = 1'b1;
        clr_fd  = 1'b0;
        clr_de  = 1'b0;
        clr_em  = 1'b0;
        pc_sel  = PC_SEL_SEQ;
        if (!rst_n) begin
            // Hold every stage with bubbles while reset is asserted.
            en_pc  = 1'b0;
            en_fd  = 1'b0;
            en_de  = 1'b0;
            en_em  = 1'b0;
            en_mw  = 1'b0;
            clr_fd = 1'b1;
            clr_de = 1'b1;
            clr_em = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (exc_req) begin
                        pc_sel  = PC_SEL_HANDLER;
                        clr_fd  = 1'b1;
                        clr_de  = 1'b1;
                        clr_em  = 1'b1;
                        state_d = ST_FLUSH;
                    end else if (eret_req) begin
                        pc_sel  = PC_SEL_EPC;
                        clr_fd  = 1'b1;
                        clr_de  = 1'b1;
                        clr_em  = 1'b1;
                        state_d = ST_FLUSH;
                    end else if (stall) begin
                        // Freeze PC and F/D, push a bubble into D/E.
                        en_pc  = 1'b0;
                        en_fd  = 1'b0;
                        clr_de = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign dbg_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_d;

    // Performance counters: stalled RUN cycles and RUN->FLUSH entries.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (run && (exc_req || eret_req)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else if (run && stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Counter registers; they wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a behavioural
// model that tracks "cycles of mult/div left" and "in recovery cycle".
module tb_pipe_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;
    localparam int CNT_W   = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4:0] d_rs, d_rt, e_waddr, m_waddr;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       e_wreg, m_wreg, d_is_md, md_start, md_is_div, exc_req, eret_req;
    logic       en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, md_busy;
    logic [1:0] pc_sel;
    logic       dbg_state;
    logic [CNT_W-1:0] dbg_md_cnt;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipe_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .e_waddr(e_waddr), .m_waddr(m_waddr), .e_wreg(e_wreg), .m_wreg(m_wreg),
        .e_tnew(e_tnew), .m_tnew(m_tnew), .d_is_md(d_is_md),
        .md_start(md_start), .md_is_div(md_is_div),
        .exc_req(exc_req), .eret_req(eret_req),
        .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
        .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em),
        .pc_sel(pc_sel), .md_busy(md_busy),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .dbg_state(dbg_state), .dbg_md_cnt(dbg_md_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    int          m_left;   // mult/div cycles still outstanding
    bit          m_flush;  // currently in the one-cycle recovery
    logic [31:0] m_sc;
    logic [31:0] m_fc;

    // Output vector: {en_pc,en_fd,en_de,en_em,en_mw, clr_fd,clr_de,clr_em, pc_sel, md_busy}
    localparam logic [10:0] O_RESET  = 11'b00000_111_00_0;
    localparam logic [10:0] O_NORMAL = 11'b11111_000_00_0;
    localparam logic [10:0] O_STALL  = 11'b00111_010_00_0;

    function automatic bit hz(input logic [4:0] r, input logic [1:0] tu);
        if (r == 5'd0) return 1'b0;
        if (e_wreg && e_waddr == r && int'(e_tnew) > int'(tu)) return 1'b1;
        if (m_wreg && m_waddr == r && int'(m_tnew) > int'(tu)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return hz(d_rs, d_tuse_rs) || hz(d_rt, d_tuse_rt) ||
               (d_is_md && (m_left > 0 || md_start));
    endfunction

    function automatic logic [10:0] m_out();
        logic [4:0] en;
        logic [2:0] clr;
        logic [1:0] ps;
        if (!rst_n) return O_RESET;
        en = 5'b11111; clr = 3'b000; ps = 2'd0;
        if (!m_flush) begin
            if (exc_req) begin
                clr = 3'b111; ps = 2'd1;
            end else if (eret_req) begin
                clr = 3'b111; ps = 2'd2;
            end else if (m_stall()) begin
                en = 5'b00111; clr = 3'b010;
            end
        end
        return {en, clr, ps, (m_left > 0)};
    endfunction

    function automatic logic [10:0] dut_out();
        return {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, pc_sel, md_busy};
    endfunction

    // Model advance on each clock edge, and immediately on reset assertion.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_flush = 0; m_sc = '0; m_fc = '0;
        end else if (m_flush) begin
            m_flush = 0;
            if (m_left > 0) m_left = m_left - 1;
        end else if (exc_req) begin
            m_left = 0; m_flush = 1; m_fc = m_fc + 1;
        end else begin
            if (eret_req) begin
                m_flush = 1; m_fc = m_fc + 1;
            end else if (m_stall()) begin
                m_sc = m_sc + 1;
            end
            if (md_start && m_left == 0) m_left = md_is_div ? DIV_LAT : MUL_LAT;
            else if (m_left > 0) m_left = m_left - 1;
        end
    end

    // Scoreboard compare, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (dut_out() !== m_out()) begin
                errors++;
                $display("FAIL outputs t=%0t act=%b exp=%b", $time, dut_out(), m_out());
            end
            checks++;
            if (dbg_state !== m_flush || dbg_md_cnt !== CNT_W'(m_left)) begin
                errors++;
                $display("FAIL state t=%0t act=%0d/%0d exp=%0d/%0d", $time,
                         dbg_state, dbg_md_cnt, m_flush, m_left);
            end
`ifdef PIPE_CTRL_PERF_EN
            checks++;
            if (stall_cycles !== m_sc || flush_count !== m_fc) begin
                errors++;
                $display("FAIL perf t=%0t act=%0d/%0d exp=%0d/%0d", $time,
                         stall_cycles, flush_count, m_sc, m_fc);
            end
`endif
        end
    end

    // Driver tasks
    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        e_waddr = 5'd0; m_waddr = 5'd0; e_wreg = 1'b0; m_wreg = 1'b0;
        e_tnew = 2'd0; m_tnew = 2'd0; d_is_md = 1'b0;
        md_start = 1'b0; md_is_div = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    endtask

    task automatic md_run(input bit is_div, input int exp_busy, input string nm);
        int bc, sc;
        bc = 0; sc = 0;
        idle_in();
        md_start = 1'b1; md_is_div = is_div; d_is_md = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (md_busy) bc++;
            if (!en_pc) sc++;
            nxt();
            md_start = 1'b0;
        end
        lit({nm, "_busy"}, bc, exp_busy);
        lit({nm, "_stall"}, sc, exp_busy + 1);
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        lit("reset_out", dut_out(), O_RESET);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();

        // Load-use: E produces r8 two cycles out, D needs it in one.
        e_wreg = 1'b1; e_waddr = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd1;
        @(negedge clk);
        lit("load_use_stall", dut_out(), O_STALL);
        nxt();
        e_tnew = 2'd1;
        @(negedge clk);
        lit("load_use_clear", dut_out(), O_NORMAL);
        nxt();

        // Register 0 and mismatched register never stall.
        idle_in();
        e_wreg = 1'b1; e_waddr = 5'd0; e_tnew = 2'd2; d_rs = 5'd0; d_tuse_rs = 2'd0;
        @(negedge clk);
        lit("reg0_nostall", dut_out(), O_NORMAL);
        nxt();
        e_waddr = 5'd8; d_rt = 5'd9; d_tuse_rt = 2'd0;
        @(negedge clk);
        lit("nomatch_nostall", dut_out(), O_NORMAL);
        nxt();

        md_run(1'b1, DIV_LAT, "div");
        md_run(1'b0, MUL_LAT, "mul");

        // Exception on the third busy cycle of a divide.
        idle_in();
        md_start = 1'b1; md_is_div = 1'b1;
        nxt();
        md_start = 1'b0;
        nxt();
        nxt();
        exc_req = 1'b1;
        @(negedge clk);
        lit("exc_in_div", dut_out(), 11'b11111_111_01_1);
        nxt();
        exc_req = 1'b0;
        @(negedge clk);
        lit("exc_flush_out", dut_out(), O_NORMAL);
        lit("exc_flush_state", dbg_state, 1);
        nxt();
        @(negedge clk);
        lit("exc_back_run", dbg_state, 0);
        nxt();

        // exc + eret + hazard together; repeat exc during FLUSH is ignored.
        idle_in();
        exc_req = 1'b1; eret_req = 1'b1;
        e_wreg = 1'b1; e_waddr = 5'd8; e_tnew = 2'd2; d_rs = 5'd8; d_tuse_rs = 2'd1;
        @(negedge clk);
        lit("exc_beats_all", dut_out(), 11'b11111_111_01_0);
        nxt();
        eret_req = 1'b0;
        @(negedge clk);
        lit("flush_ignores_exc", dut_out(), O_NORMAL);
        lit("flush_state", dbg_state, 1);
        nxt();
        exc_req = 1'b0;
        @(negedge clk);
        lit("run_after_flush", dbg_state, 0);
        lit("stall_after_flush", dut_out(), O_STALL);
        nxt();

        // Async reset in the middle of FLUSH with a multiply outstanding.
        idle_in();
        eret_req = 1'b1; md_start = 1'b1;
        @(negedge clk);
        lit("eret_out", dut_out(), 11'b11111_111_10_0);
        nxt();
        idle_in();
        #2 rst_n = 1'b0;
        #1;
        lit("async_reset_out", dut_out(), O_RESET);
        lit("async_reset_cnt", dbg_md_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();
        @(negedge clk);
        lit("post_reset_state", dbg_state, 0);
        lit("post_reset_cnt", dbg_md_cnt, 0);
`ifdef PIPE_CTRL_PERF_EN
        lit("post_reset_stalls", stall_cycles, 0);
        lit("post_reset_flushes", flush_count, 0);
`endif
        nxt();

        // Randomized traffic with a small register pool to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            d_rs      = 5'($urandom_range(0, 3));
            d_rt      = 5'($urandom_range(0, 3));
            d_tuse_rs = 2'($urandom_range(0, 3));
            d_tuse_rt = 2'($urandom_range(0, 3));
            e_waddr   = 5'($urandom_range(0, 3));
            m_waddr   = 5'($urandom_range(0, 3));
            e_wreg    = 1'($urandom_range(0, 1));
            m_wreg    = 1'($urandom_range(0, 1));
            e_tnew    = 2'($urandom_range(0, 3));
            m_tnew    = 2'($urandom_range(0, 3));
            d_is_md   = ($urandom_range(0, 2) == 0);
            md_start  = ($urandom_range(0, 3) == 0);
            md_is_div = 1'($urandom_range(0, 1));
            exc_req   = ($urandom_range(0, 19) == 0);
            eret_req  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            nxt();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
